// File: rtl/multicycle_mips.sv
// Multi-cycle MIPS core: FETCH/DECODE/EXEC/MEM/WB over one shared ALU.
// Subset: add, sub, and, or, slt, lw, sw, beq, j, jal, jr.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   IR_addr / IR           instruction address (= PC) / instruction word
//   RF_writedata / RF_we   register-file write data and commit strobe
//   dmem_req/we/addr/wdata data-memory request, held stable through MEM
//   dmem_rdata/dmem_ready  data-memory response; completes on req & ready
//   state                  FSM debug view (FETCH=0 .. WB=4)
module multicycle_mips #(
  parameter int unsigned DMEM_AW  = 7,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        IR_addr,
  input  logic [31:0]        IR,
  output logic [31:0]        RF_writedata,
  output logic               RF_we,
  output logic               dmem_req,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_wdata,
  input  logic [31:0]        dmem_rdata,
  input  logic               dmem_ready,
  output logic [2:0]         state
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned NREG = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2a;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT
  } alu_op_t;

  state_t          st;
  logic [XLEN-1:0] pc, ir_reg, a, b, alu_out, mdr;
  logic [RW-1:0]   wr_addr;
  logic [XLEN-1:0] rf [NREG];

  // Instruction fields of the latched instruction
  logic [5:0]      opcode, funct;
  logic [RW-1:0]   rs, rt, rd;
  logic [XLEN-1:0] sext, jtarget;
  logic            r_alu;

  assign opcode  = ir_reg[31:26];
  assign rs      = ir_reg[25:21];
  assign rt      = ir_reg[20:16];
  assign rd      = ir_reg[15:11];
  assign funct   = ir_reg[5:0];
  assign sext    = {{16{ir_reg[15]}}, ir_reg[15:0]};
  assign jtarget = {pc[31:28], ir_reg[25:0], 2'b00};
  assign r_alu   = (opcode == OP_RTYPE) &&
                   (funct == FN_ADD || funct == FN_SUB || funct == FN_AND ||
                    funct == FN_OR  || funct == FN_SLT);

  assign IR_addr = pc;
  assign state   = st;

  // Shared ALU: PC+4 in FETCH, operation/address/branch target in EXEC
  logic [XLEN-1:0] alu_a, alu_b, alu_y;
  alu_op_t         alu_op;

  always_comb begin
    alu_a  = pc;
    alu_b  = XLEN'(4);
    alu_op = ALU_ADD;
    if (st == S_EXEC) begin
      if (opcode == OP_RTYPE) begin
        alu_a = a;
        alu_b = b;
        case (funct)
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
      end else if (opcode == OP_LW || opcode == OP_SW) begin
        alu_a = a;
        alu_b = sext;
      end else if (opcode == OP_BEQ) begin
        alu_b = {sext[XLEN-3:0], 2'b00};
      end
    end
  end

  always_comb begin
    alu_y = '0;
    case (alu_op)
      ALU_ADD: alu_y = alu_a + alu_b;
      ALU_SUB: alu_y = alu_a - alu_b;
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_OR:  alu_y = alu_a | alu_b;
      ALU_SLT: alu_y = XLEN'($signed(alu_a) < $signed(alu_b));
      default: alu_y = '0;
    endcase
  end

  // Main FSM; RF_we/RF_writedata are loaded one edge ahead of the commit cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= S_FETCH;
      pc           <= RESET_PC;
      ir_reg       <= '0;
      a            <= '0;
      b            <= '0;
      alu_out      <= '0;
      mdr          <= '0;
      wr_addr      <= '0;
      RF_we        <= 1'b0;
      RF_writedata <= '0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_wdata   <= '0;
    end else begin
      RF_we        <= 1'b0;
      RF_writedata <= '0;
      case (st)
        S_FETCH: begin
          ir_reg <= IR;
          pc     <= alu_y;
          st     <= S_DECODE;
        end
        S_DECODE: begin
          a  <= (rs == '0) ? '0 : rf[rs];
          b  <= (rt == '0) ? '0 : rf[rt];
          st <= S_EXEC;
          // jal commits its link during EXEC; PC already holds old PC+4
          if (opcode == OP_JAL) begin
            RF_we        <= 1'b1;
            RF_writedata <= pc;
            wr_addr      <= RW'(31);
          end
        end
        S_EXEC: begin
          st <= S_FETCH;
          if (r_alu) begin
            alu_out      <= alu_y;
            RF_we        <= 1'b1;
            RF_writedata <= alu_y;
            wr_addr      <= rd;
            st           <= S_WB;
          end else if (opcode == OP_RTYPE && funct == FN_JR) begin
            pc <= a;
          end else if (opcode == OP_LW || opcode == OP_SW) begin
            alu_out    <= alu_y;
            dmem_req   <= 1'b1;
            dmem_we    <= (opcode == OP_SW);
            dmem_addr  <= alu_y[DMEM_AW+1:2];
            dmem_wdata <= b;
            st         <= S_MEM;
          end else if (opcode == OP_BEQ) begin
            if (a == b) pc <= alu_y;
          end else if (opcode == OP_J || opcode == OP_JAL) begin
            pc <= jtarget;
          end
        end
        S_MEM: begin
          if (dmem_ready) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (opcode == OP_LW) begin
              mdr          <= dmem_rdata;
              RF_we        <= 1'b1;
              RF_writedata <= dmem_rdata;
              wr_addr      <= rt;
              st           <= S_WB;
            end else begin
              st <= S_FETCH;
            end
          end
        end
        S_WB:    st <= S_FETCH;
        default: st <= S_FETCH;
      endcase
    end
  end

  // Register file; r0 writes are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (RF_we && wr_addr != '0) begin
      rf[wr_addr] <= RF_writedata;
    end
  end

  // ALUOut/MDR are architectural copies; shamt and address-truncated bits are not consumed
  logic unused_bits;
  assign unused_bits = ^{ir_reg[10:6], alu_y[XLEN-1:DMEM_AW+2], alu_y[1:0], alu_out, mdr};

endmodule

// File: tb/tb_multicycle_mips.sv
// Instruction-level bench for multicycle_mips: an ISA reference model predicts
// register writes, next PC, memory traffic and cycle counts per instruction.
module tb_multicycle_mips;

  localparam int unsigned DAW = 7;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic           clk, rst_n;
  logic [31:0]    ir_addr, ir_bus, rf_wd, dm_wdata, dm_rdata;
  logic           rf_we, dm_req, dm_we, dm_ready;
  logic [DAW-1:0] dm_addr;
  logic [2:0]     st;

  logic [31:0] imem_pc, imem_word;
  logic [31:0] mem     [2**DAW];
  logic [31:0] ref_mem [2**DAW];
  logic [31:0] regs    [32];
  logic [31:0] pc_m;
  int n_vec, n_miss;
  logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  // Only the addressed word is valid; anything else reads as an illegal opcode
  assign ir_bus = (ir_addr == imem_pc) ? imem_word : 32'hFFFF_FFFF;

  multicycle_mips #(.DMEM_AW(DAW), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n), .IR_addr(ir_addr), .IR(ir_bus),
    .RF_writedata(rf_wd), .RF_we(rf_we), .dmem_req(dm_req), .dmem_we(dm_we),
    .dmem_addr(dm_addr), .dmem_wdata(dm_wdata), .dmem_rdata(dm_rdata),
    .dmem_ready(dm_ready), .state(st)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [5:0] fn);
    return {6'h00, s, t, d, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] s,
                                         input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  function automatic int exp_state(input int c, input int mc);
    if (c < 3) return c;
    else if (c < 3 + mc) return 3;
    else return 4;
  endfunction

  // Execute one instruction on the DUT and compare with the ISA model
  task automatic run_instr(input logic [31:0] instr, input int waits, input string tag);
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, exp_wa;
    logic [31:0] se, va, vb, npc, ea, exp_wd, wd_seen;
    logic [DAW-1:0] eaddr;
    bit exp_we, is_st;
    int exp_cycles, mem_cycles, we_cyc_exp, cycles, we_cnt, we_cyc, req_cnt, wl;
    op = instr[31:26]; rs = instr[25:21]; rt = instr[20:16]; rd = instr[15:11];
    fn = instr[5:0];   se = {{16{instr[15]}}, instr[15:0]};
    va = regs[rs]; vb = regs[rt]; npc = pc_m + 32'd4;
    exp_we = 0; exp_wd = 0; exp_wa = 0; is_st = 0;
    mem_cycles = 0; exp_cycles = 3; we_cyc_exp = -1;
    ea = va + se; eaddr = ea[DAW+1:2];
    case (op)
      6'h00: begin
        exp_wa = rd;
        case (fn)
          6'h20: begin exp_we = 1; exp_wd = va + vb; end
          6'h22: begin exp_we = 1; exp_wd = va - vb; end
          6'h24: begin exp_we = 1; exp_wd = va & vb; end
          6'h25: begin exp_we = 1; exp_wd = va | vb; end
          6'h2a: begin exp_we = 1; exp_wd = ($signed(va) < $signed(vb)) ? 32'd1 : 32'd0; end
          6'h08: npc = va;
          default: ;
        endcase
        if (exp_we) begin exp_cycles = 4; we_cyc_exp = 3; end
      end
      6'h23: begin
        mem_cycles = waits + 1; exp_we = 1; exp_wa = rt; exp_wd = ref_mem[eaddr];
        exp_cycles = 4 + mem_cycles; we_cyc_exp = 3 + mem_cycles;
      end
      6'h2b: begin
        mem_cycles = waits + 1; is_st = 1; exp_cycles = 3 + mem_cycles;
      end
      6'h04: if (va == vb) npc = pc_m + 32'd4 + (se << 2);
      6'h02: npc = {npc[31:28], instr[25:0], 2'b00};
      6'h03: begin
        npc = {npc[31:28], instr[25:0], 2'b00};
        exp_we = 1; exp_wa = 5'd31; exp_wd = pc_m + 32'd4; we_cyc_exp = 2;
      end
      default: ;
    endcase

    imem_pc = pc_m; imem_word = instr;
    chk({tag, ".pc"}, ir_addr, pc_m);
    cycles = 0; we_cnt = 0; we_cyc = -1; wd_seen = 0; req_cnt = 0; wl = waits;
    do begin
      chk({tag, ".state"}, 32'(st), 32'(exp_state(cycles, mem_cycles)));
      if (rf_we) begin
        we_cnt++; we_cyc = cycles; wd_seen = rf_wd;
      end else begin
        chk({tag, ".wd_idle"}, rf_wd, 32'd0);
      end
      if (dm_req) begin
        req_cnt++;
        chk({tag, ".daddr"}, 32'(dm_addr), 32'(eaddr));
        chk({tag, ".dwe"}, 32'(dm_we), 32'(is_st));
        if (is_st) chk({tag, ".dwdata"}, dm_wdata, vb);
        if (wl == 0) begin
          dm_ready = 1'b1;
          dm_rdata = mem[dm_addr];
          if (dm_we) mem[dm_addr] = dm_wdata;
        end else begin
          dm_ready = 1'b0;
          dm_rdata = $urandom;
          wl--;
        end
      end else begin
        dm_ready = 1'($urandom);
        dm_rdata = $urandom;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end while (st != 3'd0 && cycles < 40);

    chk({tag, ".cycles"}, 32'(cycles), 32'(exp_cycles));
    chk({tag, ".we_cnt"}, 32'(we_cnt), exp_we ? 32'd1 : 32'd0);
    if (exp_we) begin
      chk({tag, ".wdata"}, wd_seen, exp_wd);
      chk({tag, ".we_cyc"}, 32'(we_cyc), 32'(we_cyc_exp));
    end
    chk({tag, ".npc"}, ir_addr, npc);
    chk({tag, ".req_cnt"}, 32'(req_cnt), 32'(mem_cycles));
    if (exp_we && exp_wa != 5'd0) regs[exp_wa] = exp_wd;
    if (is_st) begin
      ref_mem[eaddr] = vb;
      chk({tag, ".memword"}, mem[eaddr], vb);
    end
    pc_m = npc;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".state"}, 32'(st), 32'd0);
    chk({tag, ".pc"}, ir_addr, RST_PC);
    chk({tag, ".rf_we"}, 32'(rf_we), 32'd0);
    chk({tag, ".rf_wd"}, rf_wd, 32'd0);
    chk({tag, ".req"}, 32'(dm_req), 32'd0);
    chk({tag, ".we"}, 32'(dm_we), 32'd0);
    chk({tag, ".addr"}, 32'(dm_addr), 32'd0);
    chk({tag, ".wdata"}, dm_wdata, 32'd0);
  endtask

  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; dm_ready = 1'b0; dm_rdata = '0;
    imem_pc = RST_PC; imem_word = '0;
    pc_m = RST_PC;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    for (int i = 0; i < 2**DAW; i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i];
    end
    mem[0] = 32'd5; ref_mem[0] = 32'd5;
    mem[1] = 32'd7; ref_mem[1] = 32'd7;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // ALU ops on loaded operands
    run_instr(i_type(6'h23, 5'd0, 5'd1, 16'd0), 0, "lw_r1");
    run_instr(i_type(6'h23, 5'd0, 5'd2, 16'd4), 0, "lw_r2");
    run_instr(r_type(5'd1, 5'd2, 5'd3, 6'h20), 0, "add");
    run_instr(r_type(5'd1, 5'd2, 5'd4, 6'h22), 0, "sub");
    run_instr(r_type(5'd2, 5'd1, 5'd5, 6'h2a), 0, "slt");
    // Memory with three wait states
    run_instr(i_type(6'h2b, 5'd0, 5'd3, 16'd8), 3, "sw_wait");
    run_instr(i_type(6'h23, 5'd0, 5'd6, 16'd8), 3, "lw_wait");
    run_instr(r_type(5'd6, 5'd0, 5'd7, 6'h25), 0, "or_r6");
    // Jumps
    run_instr({6'h02, 26'd4}, 0, "j_0x10");
    run_instr({6'h03, 26'h40}, 0, "jal");
    run_instr(r_type(5'd31, 5'd0, 5'd0, 6'h08), 0, "jr");
    // Branches
    run_instr({6'h02, 26'd8}, 0, "j_0x20");
    run_instr(i_type(6'h04, 5'd1, 5'd1, 16'hFFFF), 0, "beq_self");
    run_instr(i_type(6'h04, 5'd1, 5'd2, 16'd4), 0, "beq_nt");
    // r0 and illegal opcode
    run_instr(r_type(5'd1, 5'd2, 5'd0, 6'h20), 0, "add_r0");
    run_instr(r_type(5'd0, 5'd1, 5'd7, 6'h20), 0, "read_r0");
    run_instr({6'h3f, 26'd0}, 0, "illegal");
    run_instr(r_type(5'd1, 5'd2, 5'd8, 6'h3f), 0, "bad_funct");

    // Randomized instruction stream
    for (int k = 0; k < 250; k++) begin
      logic [31:0] ins;
      logic [5:0]  op;
      logic [4:0]  s, t, d;
      logic [15:0] im;
      int r;
      r = $urandom_range(0, 99);
      s = 5'($urandom); t = 5'($urandom); d = 5'($urandom); im = 16'($urandom);
      if (r < 35)      ins = r_type(s, t, d, fn_tab[$urandom_range(0, 4)]);
      else if (r < 40) ins = r_type(s, t, d, 6'($urandom));
      else if (r < 55) ins = i_type(6'h23, s, t, im);
      else if (r < 68) ins = i_type(6'h2b, s, t, im);
      else if (r < 80) begin
        if ($urandom_range(0, 1) == 1) t = s;
        ins = i_type(6'h04, s, t, im);
      end
      else if (r < 86) ins = {6'h02, 26'($urandom)};
      else if (r < 92) ins = {6'h03, 26'($urandom)};
      else if (r < 95) ins = r_type(s, 5'd0, 5'd0, 6'h08);
      else begin
        op = 6'($urandom);
        if (op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h04 ||
            op == 6'h23 || op == 6'h2b) op = 6'h3f;
        ins = {op, 26'($urandom)};
      end
      run_instr(ins, $urandom_range(0, 3), "rnd");
    end

    // Reset while a load waits in MEM
    imem_pc = pc_m;
    imem_word = i_type(6'h23, 5'd0, 5'd8, 16'd0);
    dm_ready = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    chk("rstmem.state_pre", 32'(st), 32'd3);
    chk("rstmem.req_pre", 32'(dm_req), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("rstmem.state_hold", 32'(st), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmem.req", 32'(dm_req), 32'd0);
    chk("rstmem.state", 32'(st), 32'd0);
    chk("rstmem.pc", ir_addr, RST_PC);
    chk("rstmem.rf_we", 32'(rf_we), 32'd0);
    @(posedge clk); #1;
    chk("rstmem.rf_we_edge", 32'(rf_we), 32'd0);
    @(negedge clk);
    chk_reset_outputs("rstmem");
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) regs[i] = '0;
    pc_m = RST_PC;
    run_instr(i_type(6'h23, 5'd0, 5'd1, 16'd4), 1, "post_lw");
    run_instr(r_type(5'd1, 5'd2, 5'd9, 6'h20), 0, "post_add");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/multicycle_mips.md
# multicycle_mips

- Multi-cycle MIPS core: the next generation of the team's single-cycle core.
- Executes the same instruction subset: add, sub, and, or, slt, lw, sw, beq, j, jal, jr.
- Uses a five-state FSM, one shared ALU and architectural pipeline registers (IR, A, B, ALUOut, MDR).
- Talks to data memory through a req/ready handshake, so it tolerates any number of memory wait states; the data-memory address width and reset vector are parameters.

## Interface
- DMEM_AW, 7: data-memory word-address width; dmem_addr = ALU result [DMEM_AW+1:2].
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- clk  in  1  clock, all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- IR_addr  out  32  instruction address; always equals PC.
- IR  in  32  instruction word, combinational from instruction memory; sampled only in FETCH.
- RF_writedata  out  32  data being written to the register file; 0 when RF_we=0.
- RF_we  out  1  high for exactly the cycle in which a register write commits.
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = write (sw), 0 = read (lw); valid while dmem_req=1.
- dmem_addr  out  DMEM_AW  data-memory word address.
- dmem_wdata  out  32  store data (B register).
- dmem_rdata  in  32  load data; valid in a cycle where dmem_ready=1.
- dmem_ready  in  1  memory completes the request at the posedge where dmem_req=1 and dmem_ready=1.
- state  out  3  debug view of the FSM: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4.

## Operation
- **FETCH**
  - IR_reg<=IR; PC<=PC+4 → DECODE.
- **DECODE**
  - A<=RF[rs], B<=RF[rt] (reading r0 returns 0).
  - SExt = sign-extended imm16 → EXEC.
- **EXEC**
  - R-type: ALUOut<=A op B → WB.
  - lw/sw: ALUOut<=A+SExt → MEM.
  - beq: if A==B, PC<=PC+(SExt<<2) (PC is already +4) → FETCH.
  - j: PC<={PC[31:28],imm26,2'b00} → FETCH.
  - jal: PC<={PC[31:28],imm26,2'b00}; r31<=PC (= old PC+4), RF_we=1 this cycle → FETCH.
  - jr (opcode 0, funct 001000): PC<=A, no register write → FETCH.
  - Any other opcode or funct: NOP, nothing written → FETCH.
- **MEM**
  - dmem_req=1; dmem_we=1 for sw, 0 for lw; address and data held stable until completion.
  - On ready: lw MDR<=dmem_rdata → WB; sw → FETCH.
  - Without ready: stay in MEM.
- **WB**
  - lw: RF[rt]<=MDR. R-type: RF[rd]<=ALUOut. RF_we=1 → FETCH.
- **ALU**
  - 32-bit add/sub wrap modulo 2^32; no overflow trap.
  - slt is signed and yields 0 or 1.
- **Register file**
  - 32x32 storage.
  - Writes to r0 are discarded, and RF_we still pulses for them.
  - RF_writedata shows the discarded value.

## Timing
- Cycles per instruction with zero wait states:
  - beq, j, jal, jr, illegal: 3.
  - R-type: 4.
  - sw: 4.
  - lw: 5.
- Each cycle dmem_ready is held low in MEM adds one cycle.
- dmem_ready already high in the first MEM cycle completes in that cycle.
- dmem_req/we/addr/wdata are registered-state decodes: glitch-free and constant throughout MEM.
- dmem_req is 0 in every other state.
- Reset values (asynchronous):
  - state=FETCH, PC=RESET_PC, IR_addr=RESET_PC.
  - IR_reg, A, B, ALUOut, MDR and all 32 registers = 0.
  - RF_we=0, RF_writedata=0.
  - dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0.
- Reset asserted mid-MEM: dmem_req drops immediately (same delta), the pending access is abandoned, and no register write occurs.
- First posedge after rst_n deasserts samples IR at RESET_PC.
- A register written in WB or jal-EXEC is visible to the very next DECODE; no bypass is needed.

## Test plan
- **Reset and ALU ops**
  - Stimulus: reset, then `addi`-free setup via lw of 5 and 7 into r1/r2, then `add r3,r1,r2`, `sub r4,r1,r2`, `slt r5,r2,r1`.
  - Required: RF_writedata 12, then 0xFFFFFFFE, then 0, each with a single RF_we pulse; the R-type ops take 4 cycles each.
- **Load/store with wait states**
  - Stimulus: `sw r3,8(r0)` then `lw r6,8(r0)`, with dmem_ready delayed 3 cycles on both.
  - Required: dmem_addr=2, dmem_wdata=12, req held stable 4 cycles; lw writes 12 to r6; total cycle counts 7 and 8.
- **Branches**
  - Stimulus: `beq r1,r1,-1` at PC 0x20, then `beq r1,r2,+4`.
  - Required: the first branches to PC 0x20 (self-loop) with no RF_we; the not-taken beq falls through to PC+4; both take 3 cycles.
- **Jumps**
  - Stimulus: `jal 0x40` at PC 0x10, then `jr r31`.
  - Required: jal writes r31=0x14 with RF_we in EXEC and sets PC=0x100; jr returns PC to 0x14.
- **r0 and illegal opcodes**
  - Stimulus: `add r0,r1,r2`, then opcode 6'b111111.
  - Required: r0 still reads 0 afterwards; the illegal opcode completes in 3 cycles with PC+4.
- **Reset mid-MEM**
  - Stimulus: assert rst_n low while lw waits on dmem_ready=0.
  - Required: dmem_req=0 immediately, state=0, IR_addr=RESET_PC, no RF_we.
